// File: rtl/fsm_seq_gen.sv
// fsm_seq_gen: serial pattern transmitter for the '10010' sequence-detector link.
// Shifts a PAT_W-bit pattern MSB first, repeated 'reps' times, with GAP_LEN
// idle cycles between repetitions. All outputs are registered.
// Optional feature macro: FSM_SEQ_GEN_PARITY_EN appends an even-parity bit
// after every repetition (PAR state). Without it PAR is unreachable.
module fsm_seq_gen #(
    parameter int              PAT_W   = 5,
    parameter logic [PAT_W-1:0] PATTERN = 5'b10010,
    parameter int              GAP_LEN = 0,
    parameter int              REP_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pat_sel,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [REP_W-1:0] reps,
    input  logic             abort,
    output logic             a,
    output logic             a_vld,
    output logic             busy,
    output logic             done,
    output logic [1:0]       cstate
);

    localparam int CW = $clog2(PAT_W + 1);
    localparam int GW = $clog2(GAP_LEN + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        PAR  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;       // latched pattern for all repetitions
    logic [PAT_W-1:0] shreg_q, shreg_d;   // bits still to be sent this repetition
    logic [CW-1:0]    cnt_q, cnt_d;       // bits already placed on 'a' this repetition
    logic [REP_W-1:0] rep_q, rep_d;       // repetitions remaining, incl. current
    logic [GW-1:0]    gap_q, gap_d;       // idle cycles already spent in GAP
    logic             a_q, a_d;
    logic             a_vld_q, a_vld_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load;               // put MSB of latched pattern on 'a' next cycle
    logic             rep_end;            // current repetition's last bit is on 'a' now

    // Next-state and next-output computation; outputs default to idle values.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        a_d     = 1'b0;
        a_vld_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;
        rep_end = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && reps != '0) begin
                    pat_d  = pat_sel ? pat_in : PATTERN;
                    rep_d  = reps;
                    busy_d = 1'b1;
                    load   = 1'b1;
                end
            end
            SEND: begin
                if (cnt_q < CW'(PAT_W)) begin
                    a_d     = shreg_q[PAT_W-1];
                    a_vld_d = 1'b1;
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q + 1'b1;
                end else begin
`ifdef FSM_SEQ_GEN_PARITY_EN
                    state_d = PAR;
                    a_d     = ^pat_q;
                    a_vld_d = 1'b1;
`else
                    rep_end = 1'b1;
`endif
                end
            end
            GAP: begin
                if (gap_q < GW'(GAP_LEN)) begin
                    gap_d = gap_q + 1'b1;
                end else begin
                    load = 1'b1;
                end
            end
`ifdef FSM_SEQ_GEN_PARITY_EN
            PAR: begin
                rep_end = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // A repetition finished: either wrap up, idle for the gap, or restart.
        if (rep_end) begin
            rep_d = rep_q - 1'b1;
            if (rep_q == REP_W'(1)) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                cnt_d   = '0;
                shreg_d = '0;
            end else if (GAP_LEN != 0) begin
                state_d = GAP;
                gap_d   = GW'(1);
            end else begin
                load = 1'b1;
            end
        end

        if (load) begin
            state_d = SEND;
            a_d     = pat_d[PAT_W-1];
            a_vld_d = 1'b1;
            shreg_d = pat_d << 1;
            cnt_d   = CW'(1);
            gap_d   = '0;
        end

        // Abort wins over everything except in IDLE, where it is ignored.
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
            rep_d   = '0;
            gap_d   = '0;
            a_d     = 1'b0;
            a_vld_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    // State and output registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            a_q     <= 1'b0;
            a_vld_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            a_q     <= a_d;
            a_vld_q <= a_vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign a      = a_q;
    assign a_vld  = a_vld_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign cstate = state_q;

endmodule

// File: tb/tb_fsm_seq_gen.sv
// Directed bench for fsm_seq_gen: instance u0 (GAP_LEN=0) and u1 (GAP_LEN=2).
// Observed outputs are packed as {a, a_vld, busy, done, cstate[1:0]}.
module tb_fsm_seq_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic       pat_sel = 1'b0;
    logic [4:0] pat_in = 5'd0;
    logic [3:0] reps = 4'd0;
    logic       abort = 1'b0;

    logic       a0, v0, b0, d0;
    logic [1:0] c0;
    logic       a1, v1, b1, d1;
    logic [1:0] c1;

    int total = 0;
    int bad   = 0;

    localparam logic [5:0] IDLE_O = 6'b000000;
    localparam logic [5:0] DONE_O = 6'b000100;
    localparam logic [5:0] GAP_O  = 6'b001010;

    always #5 clk = ~clk;

    fsm_seq_gen #(.GAP_LEN(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .pat_sel(pat_sel),
        .pat_in(pat_in), .reps(reps), .abort(abort),
        .a(a0), .a_vld(v0), .busy(b0), .done(d0), .cstate(c0)
    );

    fsm_seq_gen #(.GAP_LEN(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .pat_sel(pat_sel),
        .pat_in(pat_in), .reps(reps), .abort(abort),
        .a(a1), .a_vld(v1), .busy(b1), .done(d1), .cstate(c1)
    );

    function automatic logic [5:0] obs(input int sel);
        return (sel == 0) ? {a0, v0, b0, d0, c0} : {a1, v1, b1, d1, c1};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input int sel, input logic [5:0] exp);
        logic [5:0] o;
        o = obs(sel);
        total++;
        assert (o === exp) else begin
            bad++;
            $error("FAIL %s: observed {a,vld,busy,done,cs}=%b expected=%b", tag, o, exp);
        end
    endtask

    // Current cycle already shows the MSB; checks every bit of one repetition
    // (plus parity when enabled) and returns one cycle after the last one.
    task automatic send_rep(input string tag, input int sel, input logic [4:0] pat);
        for (int i = 4; i >= 0; i--) begin
            chk($sformatf("%s_bit%0d", tag, 4 - i), sel, {pat[i], 5'b11001});
            tick();
        end
`ifdef FSM_SEQ_GEN_PARITY_EN
        chk($sformatf("%s_par", tag), sel, {^pat, 5'b11011});
        tick();
`endif
    endtask

    initial begin
        // reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst0", 0, IDLE_O);
        chk("rst1", 1, IDLE_O);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_after_rst", 0, IDLE_O);

        // 1: default pattern, one repetition
        pat_sel = 1'b0; reps = 4'd1; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        send_rep("t1", 0, 5'b10010);
        chk("t1_done", 0, DONE_O);
        tick();
        chk("t1_idle", 0, IDLE_O);

        // 2+3: three back-to-back reps; start/pat_in/reps while busy are ignored
        reps = 4'd3; start0 = 1'b1;
        tick();
        pat_sel = 1'b1; pat_in = 5'b11111; reps = 4'd5;
        send_rep("t2r0", 0, 5'b10010);
        send_rep("t2r1", 0, 5'b10010);
        start0 = 1'b0;
        send_rep("t2r2", 0, 5'b10010);
        chk("t2_done", 0, DONE_O);
        tick();
        chk("t2_idle", 0, IDLE_O);

        // 3: start with reps=0 ignored
        reps = 4'd0; start0 = 1'b1;
        tick();
        chk("t3_reps0_a", 0, IDLE_O);
        tick();
        chk("t3_reps0_b", 0, IDLE_O);
        start0 = 1'b0;

        // 4: user pattern, abort on 3rd bit, restart the cycle after
        pat_sel = 1'b1; pat_in = 5'b11001; reps = 4'd1; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("t4_b0", 0, 6'b111001);
        tick();
        chk("t4_b1", 0, 6'b111001);
        tick();
        chk("t4_b2", 0, 6'b011001);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_abort", 0, IDLE_O);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        send_rep("t4_restart", 0, 5'b11001);
        chk("t4_done", 0, DONE_O);
        // back-to-back start accepted in the done cycle
        pat_sel = 1'b0; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("b2b_b0", 0, 6'b111001);

        // 5: asynchronous reset during 2nd bit
        tick();
        chk("t5_b1", 0, 6'b011001);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_rst", 0, IDLE_O);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_idle_a", 0, IDLE_O);
        tick();
        chk("t5_idle_b", 0, IDLE_O);

        // abort alone in IDLE ignored; start+abort in IDLE accepted
        abort = 1'b1;
        tick();
        chk("abort_idle", 0, IDLE_O);
        start0 = 1'b1;
        tick();
        start0 = 1'b0; abort = 1'b0;
        send_rep("st_ab", 0, 5'b10010);
        chk("st_ab_done", 0, DONE_O);

        // 6: GAP_LEN=2 instance, reps=2, built-in pattern
        pat_sel = 1'b0; reps = 4'd2; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        send_rep("t6r0", 1, 5'b10010);
        chk("t6_gap0", 1, GAP_O);
        tick();
        chk("t6_gap1", 1, GAP_O);
        tick();
        send_rep("t6r1", 1, 5'b10010);
        chk("t6_done", 1, DONE_O);
        chk("t6_u0_quiet", 0, IDLE_O);

        // GAP_LEN=2 instance, user pattern 11001 (parity bit 1 when enabled)
        pat_sel = 1'b1; pat_in = 5'b11001; reps = 4'd1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        send_rep("t6u", 1, 5'b11001);
        chk("t6u_done", 1, DONE_O);
        tick();
        chk("t6u_idle", 1, IDLE_O);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
